// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: the carry chain is cut into STAGES segments, one register stage each,
// with a valid/ready handshake. Define PIPE_ADDER_SUB_EN to add the sub input and ovf output.
module pipe_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic             in_ready,
`ifdef PIPE_ADDER_SUB_EN
   input  logic             sub,
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int SEG  = (WIDTH + STAGES - 1) / STAGES;
   localparam int LAST = STAGES - 1;

   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] c_q, c_d;
   logic [STAGES-1:0] ld;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];

   logic [WIDTH-1:0]  b_eff;
   logic              c_eff;
   logic              src_v;
   logic [WIDTH-1:0]  src_a, src_b, src_s;
   logic              src_c;
   logic [WIDTH-1:0]  seg_s;
   logic              seg_c;
   int                p;

`ifdef PIPE_ADDER_SUB_EN
   assign b_eff = sub ? ~b : b;
   assign c_eff = sub ? 1'b1 : cin;
   // b_q holds the effective (possibly inverted) operand, so overflow is the plain add rule
   assign ovf   = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                  (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
`else
   assign b_eff = b;
   assign c_eff = cin;
`endif

   always_comb begin
      ld    = '0;
      v_d   = v_q;
      c_d   = c_q;
      a_d   = a_q;
      b_d   = b_q;
      s_d   = s_q;
      src_v = 1'b0;
      src_a = '0;
      src_b = '0;
      src_s = '0;
      src_c = 1'b0;
      seg_s = '0;
      seg_c = 1'b0;
      p     = 0;

      ld[LAST] = !v_q[LAST] || out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         ld[k] = !v_q[k] || ld[k+1];
      end

      for (int k = 0; k < STAGES; k++) begin
         p = (k == 0) ? 0 : k - 1;
         if (k == 0) begin
            src_v = in_valid;
            src_a = a;
            src_b = b_eff;
            src_s = '0;
            src_c = c_eff;
         end else begin
            src_v = v_q[p];
            src_a = a_q[p];
            src_b = b_q[p];
            src_s = s_q[p];
            src_c = c_q[p];
         end

         // Segments past the top bit (ceil rounding) match no bit and pass the carry through
         seg_s = src_s;
         seg_c = src_c;
         for (int i = 0; i < WIDTH; i++) begin
            if (i / SEG == k) begin
               seg_s[i] = src_a[i] ^ src_b[i] ^ seg_c;
               seg_c    = (src_a[i] & src_b[i]) | (seg_c & (src_a[i] ^ src_b[i]));
            end
         end

         if (ld[k]) begin
            v_d[k] = src_v;
            if (src_v) begin
               a_d[k] = src_a;
               b_d[k] = src_b;
               s_d[k] = seg_s;
               c_d[k] = seg_c;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         c_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         c_q <= c_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
         end
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = v_q[LAST];
   assign sum       = s_q[LAST];
   assign cout      = c_q[LAST];

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder at WIDTH=8, STAGES=4: latency, carry chain, streaming,
// backpressure, asynchronous reset, and subtract mode when PIPE_ADDER_SUB_EN is defined.
module tb_pipe_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a, b;
   logic       cin;
   logic       in_valid, in_ready;
   logic [7:0] sum;
   logic       cout, out_valid, out_ready;
`ifdef PIPE_ADDER_SUB_EN
   logic       sub, ovf;
`endif

   int total = 0;
   int bad   = 0;

   logic [8:0] q [$];
   int         bp_idx;
   logic [8:0] held;

   logic [7:0] sa  [16] = '{8'h01, 8'hFF, 8'h80, 8'h7F, 8'h55, 8'hAA, 8'h0F, 8'hF0,
                            8'h12, 8'h99, 8'hC3, 8'h3C, 8'hE1, 8'h00, 8'h64, 8'hFE};
   logic [7:0] sb  [16] = '{8'h01, 8'h01, 8'h80, 8'h01, 8'hAA, 8'h56, 8'hF1, 8'h0F,
                            8'h34, 8'h67, 8'h3D, 8'h5A, 8'h1F, 8'h00, 8'h9C, 8'hFE};
   logic [7:0] bpa [6]  = '{8'h10, 8'h20, 8'hF0, 8'h44, 8'h81, 8'hFF};
   logic [7:0] bpb [6]  = '{8'h01, 8'h22, 8'h20, 8'h44, 8'h81, 8'hFF};

   pipe_adder #(.WIDTH(8), .STAGES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef PIPE_ADDER_SUB_EN
      .sub       (sub),
      .ovf       (ovf),
`endif
      .sum       (sum),
      .cout      (cout),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] addm(input logic [7:0] x, input logic [7:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {8'd0, c};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_out(input string tag, input int maxc);
      int n = 0;
      while (!out_valid && n < maxc) begin
         tick();
         n++;
      end
      check(tag, {31'd0, out_valid}, 32'd1);
   endtask

   // One handshake cycle with scoreboard: pop on output transfer, push on input transfer
   task automatic xfer_cycle();
      #1;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            total++;
            assert (q.size() != 0)
            else begin
               bad++;
               $error("FAIL bp_extra_result observed=%0h expected=none", {cout, sum});
            end
         end else begin
            check("bp_result", {23'd0, cout, sum}, {23'd0, q.pop_front()});
         end
      end
      if (in_valid && in_ready) begin
         q.push_back(addm(a, b, cin));
         bp_idx++;
      end
      tick();
   endtask

   initial begin
      rst = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
      sub = 1'b0;
`endif
      tick();
      tick();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum", {24'd0, sum}, 32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      tick();

      // basic add: 0x3C + 0x5A = 0x96, result exactly 4 edges after acceptance
      a = 8'h3C; b = 8'h5A; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("lat_e0", {31'd0, out_valid}, 32'd0);
      tick();
      check("lat_e1", {31'd0, out_valid}, 32'd0);
      tick();
      check("lat_e2", {31'd0, out_valid}, 32'd0);
      tick();
      check("lat_e3", {31'd0, out_valid}, 32'd1);
      check("basic_sum", {24'd0, sum}, 32'h96);
      check("basic_cout", {31'd0, cout}, 32'd0);
`ifdef PIPE_ADDER_SUB_EN
      check("basic_ovf", {31'd0, ovf}, 32'd1);
`endif
      tick();

      // carry ripples through every segment
      a = 8'hFF; b = 8'h00; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out("carry_wait", 10);
      check("carry_sum", {24'd0, sum}, 32'h00);
      check("carry_cout", {31'd0, cout}, 32'd1);
      tick();
      tick();

      // streaming: 16 back-to-back operand sets
      begin
         int ri = 0;
         for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
               a = sa[c]; b = sb[c]; cin = c[0]; in_valid = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
            #1;
            if (c < 16) check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            check("stream_out_valid", {31'd0, out_valid}, {31'd0, (c >= 3 && c < 19)});
            if (out_valid && ri < 16) begin
               check("stream_result", {23'd0, cout, sum}, {23'd0, addm(sa[ri], sb[ri], ri[0])});
               ri++;
            end
         end
         check("stream_count", ri, 32'd16);
      end

      // backpressure: fill all 4 stages with out_ready low, hold 5 cycles, release
      q.delete();
      bp_idx = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         a = bpa[bp_idx]; b = bpb[bp_idx]; cin = bp_idx[0]; in_valid = 1'b1;
         xfer_cycle();
      end
      a = bpa[bp_idx]; b = bpb[bp_idx]; cin = bp_idx[0]; in_valid = 1'b1;
      #1;
      check("bp_accepted", bp_idx, 32'd4);
      check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_full_out_valid", {31'd0, out_valid}, 32'd1);
      held = {cout, sum};
      check("bp_head", {23'd0, held}, {23'd0, addm(bpa[0], bpb[0], 1'b0)});
      for (int c = 0; c < 5; c++) begin
         xfer_cycle();
         check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_stable", {23'd0, cout, sum}, {23'd0, held});
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && !(bp_idx == 6 && q.size() == 0); c++) begin
         if (bp_idx < 6) begin
            a = bpa[bp_idx]; b = bpb[bp_idx]; cin = bp_idx[0]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         xfer_cycle();
      end
      check("bp_all_sent", bp_idx, 32'd6);
      check("bp_all_drained", q.size(), 32'd0);
      check("bp_no_dup", {31'd0, out_valid}, 32'd0);

      // asynchronous reset with results in flight
      for (int c = 0; c < 4; c++) begin
         a = 8'h11 * c[7:0] + 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      check("mid_out_valid", {31'd0, out_valid}, 32'd1);
      check("mid_sum", {24'd0, sum}, 32'h33);
      #2;
      rst = 1'b1;
      #1;
      check("async_out_valid", {31'd0, out_valid}, 32'd0);
      check("async_sum", {24'd0, sum}, 32'd0);
      check("async_cout", {31'd0, cout}, 32'd0);
      #1;
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      for (int c = 0; c < 8; c++) begin
         tick();
         check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
      end

`ifdef PIPE_ADDER_SUB_EN
      // subtract: 0x80 - 0x01 = 0x7F, no borrow, signed overflow
      a = 8'h80; b = 8'h01; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; sub = 1'b0;
      wait_out("sub_wait", 10);
      check("sub_sum", {24'd0, sum}, 32'h7F);
      check("sub_cout", {31'd0, cout}, 32'd1);
      check("sub_ovf", {31'd0, ovf}, 32'd1);
      tick();
      // 0x05 - 0x07 = 0xFE with borrow, no overflow
      a = 8'h05; b = 8'h07; sub = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; sub = 1'b0;
      wait_out("sub2_wait", 10);
      check("sub2_sum", {24'd0, sum}, 32'hFE);
      check("sub2_cout", {31'd0, cout}, 32'd0);
      check("sub2_ovf", {31'd0, ovf}, 32'd0);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined ripple-carry adder; next generation of the gate-level adder cells in the GateSize flow.
- The carry chain is split into STAGES segments with a register stage after each one, so the critical path is one segment rather than WIDTH bits.
- Valid/ready handshake on both sides with per-stage bubble collapsing.
- Used as the sequential adder macro for PPA sweeps over width and pipeline depth.

Parameters:
- WIDTH, 16, operand and sum width in bits; legal range is 1 or more.
- STAGES, 4, number of pipeline segments and therefore latency in cycles; legal range is 1..WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- in_valid  input  1  a, b and cin are valid this cycle.
- in_ready  output  1  block accepts the operand set this cycle.
- sum  output  WIDTH  result, equal to (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry-out of bit WIDTH-1.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Segment width: SEG = ceil(WIDTH/STAGES). Segment k covers bits [k*SEG, min((k+1)*SEG, WIDTH)-1].
- Segments left empty by the ceil rounding are pass-through stages: they add nothing and keep the carry unchanged.
- Stage k registers the following:
  - valid bit v[k];
  - the completed sum bits for segments 0..k;
  - the still-unadded upper bits of a and b, skewed forward;
  - the carry out of segment k.
- Stage 0 adds segment 0 with cin. Stage k adds segment k with the registered carry of stage k-1.
- Latency: exactly STAGES cycles from acceptance to out_valid, with no stalls.
- Throughput: one result per cycle while out_ready=1.
- Advance rule: adv[STAGES-1] = out_ready. For stage k, stage k loads when !v[k] or adv[k+1].
- in_ready = !v[0] or adv[1]. This is combinational from out_ready through the valid chain; no registered ready.
- A transfer happens on a clock edge when valid=1 and ready=1.
- While out_valid=1 and out_ready=0, sum and cout hold stable.
- A stage that loads from an empty predecessor clears its v bit, so bubbles collapse.
- If a stage is full and its successor does not advance, the stage holds its contents.
- Outputs: out_valid = v[STAGES-1]; sum and cout come from the last stage registers.
- Reset: asynchronous assert.
  - All v bits are 0, all data registers are 0.
  - out_valid=0, sum=0, cout=0.
  - in_ready=1 on the first cycle after deassertion.
  - Reset mid-operation discards all in-flight results.
- Overflow wraps modulo 2^WIDTH; the carry is reported only on cout.
- STAGES=1: the block reduces to one registered WIDTH-bit adder.
- STAGES=WIDTH: one bit per stage.
- Data registers load only on advance, so no X propagates from idle inputs into valid results.

Optional Feature:
- Macro: PIPE_ADDER_SUB_EN.
- When defined:
  - Extra port sub (input, 1 bit), sampled with a on acceptance.
  - When sub=1, stage 0 uses ~b and carry-in 1 in place of b and cin, so sum = a - b mod 2^WIDTH.
  - cout=1 means no borrow.
  - Extra port ovf (output, 1 bit) gives signed overflow, valid with out_valid and reset to 0.
- When undefined: neither port exists and the block is add-only.

Test Plan:
- Basic add, WIDTH=8, STAGES=4: a=0x3C, b=0x5A, cin=0, out_ready=1. Expect out_valid exactly 4 cycles after acceptance, sum=0x96, cout=0.
- Carry across all segments, WIDTH=8, STAGES=4: a=0xFF, b=0x00, cin=1. Expect sum=0x00, cout=1.
- Streaming: 16 back-to-back random operands with out_ready=1. Expect 16 consecutive out_valid cycles, in order, each matching the model; in_ready stays 1.
- Backpressure: fill the pipe, then hold out_ready=0 for 5 cycles. Expect:
  - in_ready=0 once all 4 stages are valid;
  - sum and cout stable throughout;
  - no loss or duplication after release.
- Reset mid-flight: assert rst with 3 results in flight. Expect out_valid=0 and sum=0 immediately (asynchronous), and no stale results after deassertion.
- PIPE_ADDER_SUB_EN, WIDTH=8: sub=1, a=0x80, b=0x01. Expect sum=0x7F, cout=1, ovf=1.
